mfcc_frame_buffer: RTL and testbench
====================================

Name: mfcc_frame_buffer

Overview:
- Receiving end of the MFCC accelerator output stream.
- Deserialises the serial coefficient stream (NUM_MFCCS words per frame, one word per valid cycle) into frames.
- Keeps the most recent NUM_FRAMES frames as a sliding feature window in a circular buffer.
- Exposes the window to the downstream keyword classifier through a lockable random-access read port.

Parameters:
- COEF_WIDTH, 16, width of one MFCC coefficient.
- NUM_MFCCS, 13, coefficients per frame.
- NUM_FRAMES, 49, frames in the feature window.
- DROP_WIDTH, 8, width of the saturating dropped-frame counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- mfcc_in  in  COEF_WIDTH  coefficient from the MFCC pipeline.
- mfcc_in_valid  in  1  mfcc_in valid this cycle.
- sync_clr  in  1  synchronous clear: empties the window and realigns the coefficient counter.
- win_lock  in  1  consumer holds the window stable while high.
- rd_en  in  1  read request.
- rd_frame  in  clog2(NUM_FRAMES)  frame index, 0 = oldest.
- rd_coef  in  clog2(NUM_MFCCS)  coefficient index.
- rd_data  out  COEF_WIDTH  read data.
- rd_valid  out  1  rd_data valid.
- window_full  out  1  NUM_FRAMES frames stored.
- new_window  out  1  one-cycle pulse: the window advanced while full.
- frames_stored  out  clog2(NUM_FRAMES+1)  committed frame count, saturates at NUM_FRAMES.
- drop_cnt  out  DROP_WIDTH  frames discarded because of lock, saturating.

Behaviour:
- Reset values: all outputs 0; wr_slot=0; coef_cnt=0; frames_stored=0. Memory contents are don't-care.
- Storage: NUM_FRAMES+1 slots of NUM_MFCCS words.
  - Slot wr_slot is always the in-progress frame and is never part of the visible window.
  - Physical address = slot*NUM_MFCCS + coef.
- Write path, each cycle with mfcc_in_valid=1:
  - Write mfcc_in to [wr_slot][coef_cnt].
  - coef_cnt increments, wrapping NUM_MFCCS-1 -> 0.
- Commit: on the write of coef_cnt==NUM_MFCCS-1.
  - If win_lock=0 that cycle:
    - wr_slot advances mod (NUM_FRAMES+1).
    - frames_stored increments, saturating at NUM_FRAMES.
    - If frames_stored was already NUM_FRAMES, or becomes NUM_FRAMES, new_window pulses the next cycle.
  - If win_lock=1:
    - Frame discarded: wr_slot unchanged, so the slot is rewritten by the next frame.
    - drop_cnt increments, saturating at all-ones.
    - No new_window pulse.
- Visible-window mapping:
  - oldest = (wr_slot - frames_stored) mod (NUM_FRAMES+1).
  - Read slot = (oldest + rd_frame) mod (NUM_FRAMES+1); computed without a divider, using compare/subtract.
- Read port:
  - Latency 1: rd_en in cycle t gives rd_data/rd_valid in cycle t+1; rd_valid=0 otherwise.
  - rd_data holds its last value when rd_valid=0.
  - rd_frame >= frames_stored, or rd_coef >= NUM_MFCCS: rd_data=0, rd_valid=1.
  - Reads and writes in the same cycle never conflict, because the write slot is excluded from the window.
- win_lock:
  - While high, the committed window is frozen (wr_slot and frames_stored constant).
  - Writes into the in-progress slot continue.
  - Lock release takes effect for the next commit.
- sync_clr, highest priority after reset:
  - coef_cnt=0, frames_stored=0, wr_slot=0, new_window=0.
  - drop_cnt is NOT cleared.
  - A concurrent mfcc_in_valid word is ignored.
- window_full = (frames_stored==NUM_FRAMES), registered.
- Reset asserted mid-frame: the partial frame is lost and all state returns to reset values asynchronously.

Decomposition:
- Shared package mfcc_pkg: COEF_WIDTH, NUM_MFCCS, NUM_FRAMES defaults; a slot-index function computing (a+b) mod (NUM_FRAMES+1) for a,b < NUM_FRAMES+1.
- Sub-module mfcc_buf_ram: simple dual-port RAM, one write port, one registered read port, depth (NUM_FRAMES+1)*NUM_MFCCS.
- Control, counters and address mapping stay in mfcc_frame_buffer.

Test Plan (NUM_FRAMES=4, NUM_MFCCS=13 override):
- Reset, then 3 frames of value 100*f+c -> frames_stored=3, window_full=0, no new_window; read (2,5) -> rd_data=205 one cycle after rd_en.
- 4th frame -> window_full=1, single new_window pulse; 5th frame -> second pulse; read (0,0) -> 100 (frame 0 evicted).
- win_lock held high across 2 complete frames -> drop_cnt=2, window unchanged (read (0,0) returns the same value as before the lock); release, 1 frame -> new_window pulse and the window advances by one.
- sync_clr after 6 coefficients of a partial frame -> frames_stored=0, window_full=0; next 13 words form frame 0 aligned at coef 0.
- Read rd_frame=3 with frames_stored=2, and rd_coef=13 -> rd_data=0, rd_valid=1.
- Assert rst mid-frame, deassert, stream 4 frames -> outputs 0 after reset; window_full=1 after the 4th frame, contents correct.

Source files
------------

// File: rtl/mfcc_pkg.sv
// Shared defaults and slot arithmetic for the MFCC feature-window buffer.
package mfcc_pkg;

  localparam int DEF_COEF_WIDTH = 16;
  localparam int DEF_NUM_MFCCS  = 13;
  localparam int DEF_NUM_FRAMES = 49;
  localparam int DEF_DROP_WIDTH = 8;

  // (a + b) mod nslots for a, b < nslots, using one compare/subtract instead of a divider.
  function automatic logic [15:0] slot_add(input logic [15:0] a,
                                           input logic [15:0] b,
                                           input logic [15:0] nslots);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, nslots}) s = s - {1'b0, nslots};
    return s[15:0];
  endfunction

endpackage

// File: rtl/mfcc_frame_buffer_if.sv
// Stream-in, control and window read-port bundle of the MFCC frame buffer.
interface mfcc_frame_buffer_if #(
  parameter int COEF_WIDTH = 16,
  parameter int NUM_MFCCS  = 13,
  parameter int NUM_FRAMES = 49,
  parameter int DROP_WIDTH = 8
);
  localparam int FW = $clog2(NUM_FRAMES);
  localparam int CW = $clog2(NUM_MFCCS);
  localparam int SW = $clog2(NUM_FRAMES + 1);

  logic [COEF_WIDTH-1:0] mfcc_in;
  logic                  mfcc_in_valid;
  logic                  sync_clr;
  logic                  win_lock;
  logic                  rd_en;
  logic [FW-1:0]         rd_frame;
  logic [CW-1:0]         rd_coef;
  logic [COEF_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  window_full;
  logic                  new_window;
  logic [SW-1:0]         frames_stored;
  logic [DROP_WIDTH-1:0] drop_cnt;

  modport master (
    output mfcc_in, mfcc_in_valid, sync_clr, win_lock, rd_en, rd_frame, rd_coef,
    input  rd_data, rd_valid, window_full, new_window, frames_stored, drop_cnt
  );

  modport slave (
    input  mfcc_in, mfcc_in_valid, sync_clr, win_lock, rd_en, rd_frame, rd_coef,
    output rd_data, rd_valid, window_full, new_window, frames_stored, drop_cnt
  );
endinterface

// File: rtl/mfcc_buf_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module mfcc_buf_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 650,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/mfcc_frame_buffer.sv
// Deserialises the MFCC coefficient stream into frames and keeps a sliding
// window of the newest NUM_FRAMES frames behind a lockable random-access read port.
module mfcc_frame_buffer
  import mfcc_pkg::*;
#(
  parameter int COEF_WIDTH = DEF_COEF_WIDTH,
  parameter int NUM_MFCCS  = DEF_NUM_MFCCS,
  parameter int NUM_FRAMES = DEF_NUM_FRAMES,
  parameter int DROP_WIDTH = DEF_DROP_WIDTH
) (
  input logic                clk,
  input logic                rst,
  mfcc_frame_buffer_if.slave bus
);
  localparam int NSLOT = NUM_FRAMES + 1;
  localparam int DEPTH = NSLOT * NUM_MFCCS;
  localparam int AW    = $clog2(DEPTH);
  localparam int SW    = $clog2(NSLOT);
  localparam int CW    = $clog2(NUM_MFCCS);

  logic [CW-1:0]         coef_cnt_q, coef_cnt_d;
  logic [SW-1:0]         wr_slot_q, wr_slot_d;
  logic [SW-1:0]         frames_q, frames_d;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;
  logic                  new_win_q, new_win_d;
  logic                  full_q;
  logic                  rd_valid_q;
  logic                  oor_q;

  logic                  we_w, last_w, oor_w;
  logic [SW-1:0]         oldest_w, rd_slot_w;
  logic [AW-1:0]         waddr_w, raddr_w;
  logic [COEF_WIDTH-1:0] ram_rdata;

  assign we_w    = bus.mfcc_in_valid && !bus.sync_clr;
  assign last_w  = (coef_cnt_q == CW'(NUM_MFCCS - 1));
  assign waddr_w = AW'(wr_slot_q) * AW'(NUM_MFCCS) + AW'(coef_cnt_q);

  always_comb begin
    coef_cnt_d = coef_cnt_q;
    wr_slot_d  = wr_slot_q;
    frames_d   = frames_q;
    drop_d     = drop_q;
    new_win_d  = 1'b0;
    if (bus.sync_clr) begin
      coef_cnt_d = '0;
      wr_slot_d  = '0;
      frames_d   = '0;
    end else if (we_w) begin
      coef_cnt_d = last_w ? '0 : coef_cnt_q + 1'b1;
      if (last_w) begin
        if (!bus.win_lock) begin
          wr_slot_d = SW'(slot_add(16'(wr_slot_q), 16'd1, 16'(NSLOT)));
          if (frames_q != SW'(NUM_FRAMES)) frames_d = frames_q + 1'b1;
          new_win_d = (frames_q >= SW'(NUM_FRAMES - 1));
        end else if (!(&drop_q)) begin
          drop_d = drop_q + 1'b1;
        end
      end
    end
  end

  // Oldest visible slot sits frames_stored slots behind the in-progress slot.
  assign oldest_w  = (wr_slot_q >= frames_q) ? (wr_slot_q - frames_q)
                                             : (wr_slot_q + SW'(NSLOT) - frames_q);
  assign rd_slot_w = SW'(slot_add(16'(oldest_w), 16'(bus.rd_frame), 16'(NSLOT)));
  assign raddr_w   = AW'(rd_slot_w) * AW'(NUM_MFCCS) + AW'(bus.rd_coef);
  assign oor_w     = (SW'(bus.rd_frame) >= frames_q) || (32'(bus.rd_coef) >= NUM_MFCCS);

  mfcc_buf_ram #(
    .DATA_W (COEF_WIDTH),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we_w),
    .waddr (waddr_w),
    .wdata (bus.mfcc_in),
    .re    (bus.rd_en && !oor_w),
    .raddr (raddr_w),
    .rdata (ram_rdata)
  );

  // oor_q resets high so rd_data reads 0 without resetting the RAM output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_cnt_q <= '0;
      wr_slot_q  <= '0;
      frames_q   <= '0;
      drop_q     <= '0;
      new_win_q  <= 1'b0;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      oor_q      <= 1'b1;
    end else begin
      coef_cnt_q <= coef_cnt_d;
      wr_slot_q  <= wr_slot_d;
      frames_q   <= frames_d;
      drop_q     <= drop_d;
      new_win_q  <= new_win_d;
      full_q     <= (frames_d == SW'(NUM_FRAMES));
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) oor_q <= oor_w;
    end
  end

  assign bus.rd_data       = oor_q ? '0 : ram_rdata;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.window_full   = full_q;
  assign bus.new_window    = new_win_q;
  assign bus.frames_stored = frames_q;
  assign bus.drop_cnt      = drop_q;
endmodule

// File: tb/tb_mfcc_frame_buffer.sv
// Directed bench for mfcc_frame_buffer with a 4-frame, 13-coefficient window.
module tb_mfcc_frame_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mfcc_frame_buffer_if #(.COEF_WIDTH(16), .NUM_MFCCS(13), .NUM_FRAMES(4), .DROP_WIDTH(8)) bus ();

  mfcc_frame_buffer #(.COEF_WIDTH(16), .NUM_MFCCS(13), .NUM_FRAMES(4), .DROP_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_words(input int base, input int n);
    for (int c = 0; c < n; c++) begin
      bus.mfcc_in       = 16'(base + c);
      bus.mfcc_in_valid = 1'b1;
      tick();
    end
    bus.mfcc_in_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, output int pulses);
    pulses = 0;
    for (int c = 0; c < 13; c++) begin
      bus.mfcc_in       = 16'(base + c);
      bus.mfcc_in_valid = 1'b1;
      tick();
      if (bus.new_window) pulses++;
    end
    bus.mfcc_in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (bus.new_window) pulses++;
    end
  endtask

  task automatic do_read(input int f, input int c, output int data, output int vld);
    bus.rd_en    = 1'b1;
    bus.rd_frame = 2'(f);
    bus.rd_coef  = 4'(c);
    tick();
    data      = int'(bus.rd_data);
    vld       = int'(bus.rd_valid);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p, d, v;
    bus.mfcc_in = '0; bus.mfcc_in_valid = 1'b0; bus.sync_clr = 1'b0;
    bus.win_lock = 1'b0; bus.rd_en = 1'b0; bus.rd_frame = '0; bus.rd_coef = '0;
    repeat (3) tick();
    check("rst_frames", 32'(bus.frames_stored), 0);
    check("rst_full",   32'(bus.window_full), 0);
    check("rst_newwin", 32'(bus.new_window), 0);
    check("rst_drop",   32'(bus.drop_cnt), 0);
    check("rst_rdvld",  32'(bus.rd_valid), 0);
    check("rst_rddata", 32'(bus.rd_data), 0);
    rst = 1'b0;
    tick();

    // Fill three frames
    for (int f = 0; f < 3; f++) begin
      send_frame(100 * f, p);
      check("fill_nopulse", p, 0);
    end
    check("fill3_frames", 32'(bus.frames_stored), 3);
    check("fill3_full",   32'(bus.window_full), 0);
    check("pre_read_vld", 32'(bus.rd_valid), 0);
    do_read(2, 5, d, v);
    check("rd25_data", d, 205);
    check("rd25_vld",  v, 1);
    tick();
    check("rd_vld_drop", 32'(bus.rd_valid), 0);
    check("rd_hold",     32'(bus.rd_data), 205);

    send_frame(300, p);
    check("f4_pulse", p, 1);
    check("f4_full",  32'(bus.window_full), 1);
    check("f4_frames", 32'(bus.frames_stored), 4);
    send_frame(400, p);
    check("f5_pulse", p, 1);
    check("f5_frames", 32'(bus.frames_stored), 4);
    do_read(0, 0, d, v);
    check("evict_rd00", d, 100);
    do_read(3, 12, d, v);
    check("newest_rd312", d, 412);

    // Lock across two frames
    bus.win_lock = 1'b1;
    send_frame(500, p);
    check("lock1_pulse", p, 0);
    send_frame(600, p);
    check("lock2_pulse", p, 0);
    check("lock_drop", 32'(bus.drop_cnt), 2);
    check("lock_frames", 32'(bus.frames_stored), 4);
    do_read(0, 0, d, v);
    check("lock_rd00", d, 100);
    do_read(3, 12, d, v);
    check("lock_rd312", d, 412);
    bus.win_lock = 1'b0;
    send_frame(700, p);
    check("unlock_pulse", p, 1);
    do_read(0, 0, d, v);
    check("unlock_rd00", d, 200);
    do_read(3, 3, d, v);
    check("unlock_rd33", d, 703);

    // Clear mid-frame; the concurrent word is dropped
    send_words(800, 6);
    bus.sync_clr = 1'b1; bus.mfcc_in = 16'd999; bus.mfcc_in_valid = 1'b1;
    tick();
    bus.sync_clr = 1'b0; bus.mfcc_in_valid = 1'b0;
    tick();
    check("clr_frames", 32'(bus.frames_stored), 0);
    check("clr_full",   32'(bus.window_full), 0);
    check("clr_drop",   32'(bus.drop_cnt), 2);
    send_frame(1000, p);
    check("clr_f0_frames", 32'(bus.frames_stored), 1);
    do_read(0, 0, d, v);
    check("clr_rd00", d, 1000);
    do_read(0, 12, d, v);
    check("clr_rd012", d, 1012);
    send_frame(1100, p);
    check("clr_f1_frames", 32'(bus.frames_stored), 2);
    do_read(1, 7, d, v);
    check("clr_rd17", d, 1107);

    // Out-of-range reads
    do_read(3, 0, d, v);
    check("oor_frame_data", d, 0);
    check("oor_frame_vld",  v, 1);
    do_read(1, 6, d, v);
    check("inrange_rd16", d, 1106);
    do_read(0, 13, d, v);
    check("oor_coef_data", d, 0);
    check("oor_coef_vld",  v, 1);

    // Asynchronous reset mid-frame
    send_words(1200, 5);
    #2;
    rst = 1'b1;
    #1;
    check("arst_frames", 32'(bus.frames_stored), 0);
    check("arst_drop",   32'(bus.drop_cnt), 0);
    check("arst_rdvld",  32'(bus.rd_valid), 0);
    tick();
    rst = 1'b0;
    tick();
    d = 0;
    for (int f = 0; f < 4; f++) begin
      send_frame(2000 + 100 * f, p);
      d += p;
    end
    check("arst_pulses", d, 1);
    check("arst_full",   32'(bus.window_full), 1);
    do_read(0, 0, d, v);
    check("arst_rd00", d, 2000);
    do_read(1, 6, d, v);
    check("arst_rd16", d, 2106);
    do_read(3, 12, d, v);
    check("arst_rd312", d, 2312);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
